ccd_frame_capture: RTL and testbench
====================================

CCD_FRAME_CAPTURE -- requirements
Module: ccd_frame_capture

Interface
REQ-001 The module SHALL have a parameter COLUMN_WIDTH, default 1280, giving the number of valid pixels per sensor line.
REQ-002 The module SHALL have port iCLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port iRST, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The module SHALL have port iDATA, input, 12 bits: raw Bayer pixel from the sensor.
REQ-005 The module SHALL have port iFVAL, input, 1 bit: sensor frame-valid.
REQ-006 The module SHALL have port iLVAL, input, 1 bit: sensor line-valid.
REQ-007 The module SHALL have port iSTART, input, 1 bit: capture enable request, level-sampled.
REQ-008 The module SHALL have port iEND, input, 1 bit: capture disable request, level-sampled.
REQ-009 The module SHALL have port oDATA, output, 12 bits: pixel forwarded to the demosaic stage.
REQ-010 The module SHALL have port oDVAL, output, 1 bit: oDATA valid.
REQ-011 The module SHALL have port oX_Cont, output, 11 bits: column index of the pixel on oDATA.
REQ-012 The module SHALL have port oY_Cont, output, 11 bits: row index of the pixel on oDATA.
REQ-013 The module SHALL have port oFrame_Cont, output, 32 bits: number of frames started since reset.

Function
REQ-014 The module SHALL register iDATA, iFVAL and iLVAL into rDATA, rFVAL and rLVAL every cycle; no other logic SHALL use the raw inputs except iSTART and iEND.
REQ-015 The module SHALL register rFVAL into Pre_FVAL every cycle for edge detection.
REQ-016 The run flag SHALL be set by iSTART=1 and cleared by iEND=1; when both are 1 in the same cycle, iEND SHALL win and run SHALL be 0.
REQ-017 The frame flag mFVAL SHALL go 0->1 at the edge where rFVAL=1, Pre_FVAL=0 and run=1.
REQ-018 mFVAL SHALL go 1->0 at the edge where rFVAL=0 and Pre_FVAL=1, independent of run.
REQ-019 Clearing run mid-frame SHALL let the current frame finish; setting run mid-frame SHALL NOT start capture before the next iFVAL rising edge. No partial frames are ever output.
REQ-020 oDVAL SHALL equal mFVAL AND rLVAL (combinational from registers).
REQ-021 oDATA SHALL equal rDATA when rLVAL=1, else 0.
REQ-022 Latency SHALL be one cycle: a pixel sampled with iLVAL=1 at edge n appears on oDATA/oDVAL during the cycle after edge n.
REQ-023 While mFVAL=0, the X and Y counters SHALL be held at 0.
REQ-024 While mFVAL=1 and rLVAL=1, X SHALL increment at each edge; at X=COLUMN_WIDTH-1, X SHALL wrap to 0 and Y SHALL increment.
REQ-025 While mFVAL=1 and rLVAL=0, X and Y SHALL hold; line wrap is count-based only.
REQ-026 Y SHALL wrap modulo 2048 without error indication.
REQ-027 oX_Cont/oY_Cont SHALL show the counter values before the update, so the first valid pixel of a frame carries X=0, Y=0.
REQ-028 oFrame_Cont SHALL increment by 1 at each mFVAL 0->1 transition, wrapping modulo 2^32.

Reset
REQ-029 While iRST=0, all registers SHALL asynchronously clear to 0: rDATA, rFVAL, rLVAL, Pre_FVAL, run, mFVAL, X, Y and frame count. As a result oDATA=0, oDVAL=0, oX_Cont=0, oY_Cont=0 and oFrame_Cont=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately. After release, capture SHALL require a new iSTART and a new iFVAL rising edge.

Verification
REQ-031 Reset: assert iRST=0 mid-frame -> all outputs 0 in the same cycle; no oDVAL after release until iSTART plus a new iFVAL rise.
REQ-032 Nominal frame, COLUMN_WIDTH=8: iSTART pulse, iFVAL=1, two blank cycles, then 6 lines of 8 pixels 0x001..0x030 with iLVAL gaps between lines -> 48 oDVAL cycles; oDATA 0x001..0x030 in order; X 0..7 per line; Y 0..5; oFrame_Cont=1.
REQ-033 Late start: iSTART asserted while iFVAL is already high -> zero oDVAL for that frame; the next frame is captured and oFrame_Cont goes 0->1 at its start.
REQ-034 Stop mid-frame: iEND during line 3 -> lines 3..5 still output, with 48 pixels total; the next frame produces no oDVAL and oFrame_Cont stays 1.
REQ-035 Simultaneous iSTART=1 and iEND=1 for one cycle with run=0 -> run stays 0; the following frame is not captured.
REQ-036 Gapped pixels: iLVAL toggling 1/0 every cycle inside a line -> X increments only on valid pixels, wraps at 8 after 8 valid pixels, and Y increments exactly once.

Source files
------------

// File: rtl/ccd_frame_capture.sv
// CCD frame capture front end.
// Registers the raw sensor stream and gates it so that only whole frames
// are forwarded, starting at a frame-valid rising edge seen while capture
// is enabled. Column and row counters tag each forwarded pixel, and a
// frame counter counts the frames started since reset.
module ccd_frame_capture #(
   parameter int COLUMN_WIDTH = 1280
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic [11:0] iDATA,
   input  logic        iFVAL,
   input  logic        iLVAL,
   input  logic        iSTART,
   input  logic        iEND,
   output logic [11:0] oDATA,
   output logic        oDVAL,
   output logic [10:0] oX_Cont,
   output logic [10:0] oY_Cont,
   output logic [31:0] oFrame_Cont
);

   // Last column index of a line; the column counter wraps after it.
   localparam logic [10:0] X_LAST = 11'(COLUMN_WIDTH - 1);

   logic [11:0] data_r;
   logic        fval_r;
   logic        lval_r;
   logic        pre_fval_r;
   logic        run_r;
   logic        mfval_r;
   logic [10:0] x_r;
   logic [10:0] y_r;
   logic [31:0] frame_cnt_r;

   logic        frame_rise_s;
   logic        frame_fall_s;

   // A frame may only open on a registered frame-valid rise while enabled;
   // it always closes on the registered fall, whatever the enable says.
   assign frame_rise_s = fval_r & ~pre_fval_r & run_r;
   assign frame_fall_s = ~fval_r & pre_fval_r;

   // Input stage: every sensor signal used by the core goes through here.
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         data_r     <= 12'h000;
         fval_r     <= 1'b0;
         lval_r     <= 1'b0;
         pre_fval_r <= 1'b0;
      end else begin
         data_r     <= iDATA;
         fval_r     <= iFVAL;
         lval_r     <= iLVAL;
         pre_fval_r <= fval_r;
      end
   end

   // Capture enable: a stop request overrides a simultaneous start request.
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         run_r <= 1'b0;
      end else if (iEND) begin
         run_r <= 1'b0;
      end else if (iSTART) begin
         run_r <= 1'b1;
      end else begin
         run_r <= run_r;
      end
   end

   // Frame window and frame counter; the counter steps once per opened frame.
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         mfval_r     <= 1'b0;
         frame_cnt_r <= 32'd0;
      end else if (frame_rise_s && !mfval_r) begin
         mfval_r     <= 1'b1;
         frame_cnt_r <= frame_cnt_r + 32'd1;
      end else if (frame_fall_s) begin
         mfval_r     <= 1'b0;
         frame_cnt_r <= frame_cnt_r;
      end else begin
         mfval_r     <= mfval_r;
         frame_cnt_r <= frame_cnt_r;
      end
   end

   // Pixel position: counts valid pixels only; rows advance purely by count.
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         x_r <= 11'd0;
         y_r <= 11'd0;
      end else if (!mfval_r) begin
         x_r <= 11'd0;
         y_r <= 11'd0;
      end else if (lval_r) begin
         if (x_r == X_LAST) begin
            x_r <= 11'd0;
            y_r <= y_r + 11'd1;
         end else begin
            x_r <= x_r + 11'd1;
            y_r <= y_r;
         end
      end else begin
         x_r <= x_r;
         y_r <= y_r;
      end
   end

   // Outputs come straight from registers; the counters show their value
   // before this pixel's update, so a frame's first pixel is at (0,0).
   assign oDATA       = lval_r ? data_r : 12'h000;
   assign oDVAL       = mfval_r & lval_r;
   assign oX_Cont     = x_r;
   assign oY_Cont     = y_r;
   assign oFrame_Cont = frame_cnt_r;

endmodule

// File: tb/tb_ccd_frame_capture.sv
// Testbench for ccd_frame_capture with an 8-pixel line. Frames are described
// at pixel level; the expected output of a captured frame is simply its list
// of valid pixels in order, tagged with (index mod 8, index div 8).
module tb_ccd_frame_capture;

   localparam int COLW = 8;

   logic        iCLK;
   logic        iRST;
   logic [11:0] iDATA;
   logic        iFVAL;
   logic        iLVAL;
   logic        iSTART;
   logic        iEND;
   logic [11:0] oDATA;
   logic        oDVAL;
   logic [10:0] oX_Cont;
   logic [10:0] oY_Cont;
   logic [31:0] oFrame_Cont;

   typedef struct packed {
      logic [11:0] d;
      logic [10:0] x;
      logic [10:0] y;
   } pix_t;

   pix_t exp_q[$];
   pix_t got_q[$];
   int   checks   = 0;
   int   failures = 0;

   ccd_frame_capture #(.COLUMN_WIDTH(COLW)) dut (
      .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iFVAL(iFVAL), .iLVAL(iLVAL),
      .iSTART(iSTART), .iEND(iEND), .oDATA(oDATA), .oDVAL(oDVAL),
      .oX_Cont(oX_Cont), .oY_Cont(oY_Cont), .oFrame_Cont(oFrame_Cont)
   );

   initial begin
      iCLK = 1'b0;
      forever #5 iCLK = ~iCLK;
   end

   // Collect every forwarded pixel, away from the active edge.
   always @(negedge iCLK) begin
      if (iRST === 1'b1 && oDVAL === 1'b1) got_q.push_back({oDATA, oX_Cont, oY_Cont});
   end

   task automatic tick();
      @(posedge iCLK);
      #1;
   endtask

   task automatic do_reset();
      iRST = 1'b0; iDATA = 12'h000; iFVAL = 1'b0; iLVAL = 1'b0;
      iSTART = 1'b0; iEND = 1'b0;
      tick(); tick();
      iRST = 1'b1;
      tick(); tick();
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic pulse(input logic s, input logic e);
      iSTART = s; iEND = e;
      tick();
      iSTART = 1'b0; iEND = 1'b0;
      tick();
   endtask

   // Drive one frame of nlines x COLW valid pixels; when capture is set the
   // pixels are appended to the expected list.
   task automatic send_frame(input int nlines, input bit gapped, input bit capture,
                             input int end_line, input bit late_start, input bit fixed_data);
      int k;
      k = 0;
      iFVAL = 1'b1; iLVAL = 1'b0;
      tick();
      if (late_start) iSTART = 1'b1;
      tick();
      iSTART = 1'b0;
      tick();
      for (int l = 0; l < nlines; l++) begin
         for (int p = 0; p < COLW; p++) begin
            if (l == end_line && p == 0) iEND = 1'b1;
            iLVAL = 1'b1;
            iDATA = fixed_data ? 12'(k + 1) : 12'($urandom);
            if (capture) exp_q.push_back({iDATA, 11'(k % COLW), 11'(k / COLW)});
            k++;
            tick();
            iEND = 1'b0;
            if (gapped) begin
               iLVAL = 1'b0; iDATA = 12'($urandom);
               tick();
            end
         end
         iLVAL = 1'b0; iDATA = 12'h000;
         tick(); tick();
      end
      iFVAL = 1'b0;
      tick(); tick(); tick();
   endtask

   task automatic test_reset();
      iRST = 1'b0; iDATA = 12'hABC; iFVAL = 1'b1; iLVAL = 1'b1;
      iSTART = 1'b1; iEND = 1'b0;
      tick(); tick();
      checks += 5;
      if (oDATA !== 12'h000) begin failures++; $display("FAIL reset_data got=%h exp=000", oDATA); end
      if (oDVAL !== 1'b0) begin failures++; $display("FAIL reset_dval got=%b exp=0", oDVAL); end
      if (oX_Cont !== 11'd0) begin failures++; $display("FAIL reset_x got=%0d exp=0", oX_Cont); end
      if (oY_Cont !== 11'd0) begin failures++; $display("FAIL reset_y got=%0d exp=0", oY_Cont); end
      if (oFrame_Cont !== 32'd0) begin failures++; $display("FAIL reset_frame got=%0d exp=0", oFrame_Cont); end
      do_reset();
   endtask

   task automatic test_nominal();
      do_reset();
      pulse(1'b1, 1'b0);
      send_frame(6, 1'b0, 1'b1, -1, 1'b0, 1'b1);
      checks++;
      if (got_q.size() !== 48) begin failures++; $display("FAIL nominal_count got=%0d exp=48", got_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL nominal_pix[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      checks++;
      if (oFrame_Cont !== 32'd1) begin failures++; $display("FAIL nominal_frame got=%0d exp=1", oFrame_Cont); end
   endtask

   task automatic test_late_start();
      do_reset();
      send_frame(2, 1'b0, 1'b0, -1, 1'b1, 1'b0);
      checks += 2;
      if (got_q.size() !== 0) begin failures++; $display("FAIL late_count got=%0d exp=0", got_q.size()); end
      if (oFrame_Cont !== 32'd0) begin failures++; $display("FAIL late_frame got=%0d exp=0", oFrame_Cont); end
      send_frame(2, 1'b0, 1'b1, -1, 1'b0, 1'b0);
      checks++;
      if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL late_next_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL late_pix[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      checks++;
      if (oFrame_Cont !== 32'd1) begin failures++; $display("FAIL late_next_frame got=%0d exp=1", oFrame_Cont); end
   endtask

   task automatic test_stop_mid_frame();
      do_reset();
      pulse(1'b1, 1'b0);
      send_frame(6, 1'b0, 1'b1, 3, 1'b0, 1'b0);
      checks++;
      if (got_q.size() !== 48) begin failures++; $display("FAIL stop_count got=%0d exp=48", got_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL stop_pix[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      got_q.delete(); exp_q.delete();
      send_frame(2, 1'b0, 1'b0, -1, 1'b0, 1'b0);
      checks += 2;
      if (got_q.size() !== 0) begin failures++; $display("FAIL stop_next_count got=%0d exp=0", got_q.size()); end
      if (oFrame_Cont !== 32'd1) begin failures++; $display("FAIL stop_frame got=%0d exp=1", oFrame_Cont); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      pulse(1'b1, 1'b1);
      send_frame(2, 1'b0, 1'b0, -1, 1'b0, 1'b0);
      checks += 2;
      if (got_q.size() !== 0) begin failures++; $display("FAIL simul_count got=%0d exp=0", got_q.size()); end
      if (oFrame_Cont !== 32'd0) begin failures++; $display("FAIL simul_frame got=%0d exp=0", oFrame_Cont); end
   endtask

   task automatic test_gapped();
      do_reset();
      pulse(1'b1, 1'b0);
      send_frame(2, 1'b1, 1'b1, -1, 1'b0, 1'b0);
      checks++;
      if (got_q.size() !== 16) begin failures++; $display("FAIL gap_count got=%0d exp=16", got_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL gap_pix[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      pulse(1'b1, 1'b0);
      iFVAL = 1'b1;
      tick(); tick(); tick();
      for (int p = 0; p < 5; p++) begin
         iLVAL = 1'b1; iDATA = 12'($urandom_range(1, 4095));
         tick();
      end
      checks++;
      if (oDVAL !== 1'b1) begin failures++; $display("FAIL rstmid_pre_dval got=%b exp=1", oDVAL); end
      iRST = 1'b0;
      #1;
      checks += 5;
      if (oDATA !== 12'h000) begin failures++; $display("FAIL rstmid_data got=%h exp=000", oDATA); end
      if (oDVAL !== 1'b0) begin failures++; $display("FAIL rstmid_dval got=%b exp=0", oDVAL); end
      if (oX_Cont !== 11'd0) begin failures++; $display("FAIL rstmid_x got=%0d exp=0", oX_Cont); end
      if (oY_Cont !== 11'd0) begin failures++; $display("FAIL rstmid_y got=%0d exp=0", oY_Cont); end
      if (oFrame_Cont !== 32'd0) begin failures++; $display("FAIL rstmid_frame got=%0d exp=0", oFrame_Cont); end
      tick();
      iRST = 1'b1;
      got_q.delete(); exp_q.delete();
      tick(); tick(); tick();
      pulse(1'b1, 1'b0);
      for (int p = 0; p < COLW; p++) begin
         iLVAL = 1'b1; iDATA = 12'($urandom);
         tick();
      end
      iLVAL = 1'b0; iFVAL = 1'b0;
      tick(); tick(); tick();
      checks += 2;
      if (got_q.size() !== 0) begin failures++; $display("FAIL rstmid_after_count got=%0d exp=0", got_q.size()); end
      if (oFrame_Cont !== 32'd0) begin failures++; $display("FAIL rstmid_after_frame got=%0d exp=0", oFrame_Cont); end
      send_frame(1, 1'b0, 1'b1, -1, 1'b0, 1'b0);
      checks += 2;
      if (got_q.size() !== 8) begin failures++; $display("FAIL rstmid_new_count got=%0d exp=8", got_q.size()); end
      if (oFrame_Cont !== 32'd1) begin failures++; $display("FAIL rstmid_new_frame got=%0d exp=1", oFrame_Cont); end
   endtask

   task automatic test_random_frames();
      bit run;
      bit s;
      bit e;
      int exp_frames;
      do_reset();
      run = 1'b0;
      exp_frames = 0;
      for (int f = 0; f < 8; f++) begin
         s = 1'($urandom_range(0, 1));
         e = ($urandom_range(0, 3) == 0);
         pulse(s, e);
         if (e) run = 1'b0;
         else if (s) run = 1'b1;
         if (run) exp_frames++;
         got_q.delete(); exp_q.delete();
         send_frame($urandom_range(1, 3), 1'($urandom_range(0, 1)), run, -1, 1'b0, 1'b0);
         checks++;
         if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL rand%0d_count got=%0d exp=%0d", f, got_q.size(), exp_q.size()); end
         for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand%0d_pix[%0d] got=%h exp=%h", f, i, got_q[i], exp_q[i]); end
         end
         checks++;
         if (oFrame_Cont !== 32'(exp_frames)) begin failures++; $display("FAIL rand%0d_frame got=%0d exp=%0d", f, oFrame_Cont, exp_frames); end
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_late_start();
      test_stop_mid_frame();
      test_simultaneous();
      test_gapped();
      test_reset_mid_frame();
      test_random_frames();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
